// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes,
// opcode constants and the datapath select encodings the FSM drives.
package ctrl_pkg;

  // State codes double as the debug value on the state port.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_PERF   = 4'd13
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_PERF = 6'b110011;

  localparam logic [1:0] ALU_FUNCT = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_SLT   = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // States that wait on the memory handshake.
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// Cycle and retired-instruction counters for the multi-cycle controller.
// Both wrap; a clear request wins over a same-cycle increment.
module ctrl_perf_counters #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_count,
  input  logic         i_retire,
  input  logic         i_clear,
  output logic [W-1:0] o_cycle_cnt,
  output logic [W-1:0] o_instr_cnt
);

  logic [W-1:0] r_cycle_cnt;
  logic [W-1:0] r_instr_cnt;

  // Count active cycles and retirements; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else if (i_clear) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (i_count)  r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (i_retire) r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
  assign o_instr_cnt = r_instr_cnt;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM (Moore). Sequences each instruction over
// 3-5 cycles, stalls on the memory handshake, flags unknown opcodes and
// optionally aborts long stalls (STALL_MAX != 0).
// Optional feature macro: PERF_COUNTERS_EN adds cycle_cnt / instr_cnt.
//
// Memory handshake: mem_read / mem_write are held for as long as the FSM
// sits in FETCH, MEMRD or MEMWR; the access completes in the cycle where
// mem_ready is high, and the FSM advances on that clock edge. mem_ready is
// ignored in every other state.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int PERF_CNT_W = 32,
  parameter int STALL_MAX  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       sign_or_zero,
  output logic       perf,
  output logic       retire,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [PERF_CNT_W-1:0] cycle_cnt,
  output logic [PERF_CNT_W-1:0] instr_cnt
`endif
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [5:0] r_op;
  logic       w_wait;
  logic       w_known;
  logic       w_timeout;
  logic [1:0] w_imm_alu;
  logic       w_imm_sext;

  assign w_wait     = is_wait_state(r_state);
  assign w_imm_alu  = (r_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
  assign w_imm_sext = (r_op != OP_SLTI);

  // Recognised opcodes; anything else is flagged in DECODE.
  always_comb begin
    w_known = 1'b0;
    case (opcode)
      OP_R, OP_J, OP_JAL, OP_BEQ, OP_ADDI,
      OP_SLTI, OP_LW, OP_SW, OP_PERF: w_known = 1'b1;
      default: w_known = 1'b0;
    endcase
  end

  // Stall watchdog: counts consecutive stalled cycles in one wait state and
  // fires when a further stall would exceed STALL_MAX. mem_ready wins.
  generate
    if (STALL_MAX != 0) begin : g_wdog
      localparam int SW = $clog2(STALL_MAX + 2);
      logic [SW-1:0] r_stall;

      // Clear on any state change or abort, count stalled wait cycles.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                r_stall <= '0;
        else if ((w_next != r_state) || w_timeout) r_stall <= '0;
        else if (w_wait && !mem_ready)             r_stall <= r_stall + 1'b1;
      end

      assign w_timeout = w_wait && !mem_ready && (r_stall == SW'(STALL_MAX));
    end else begin : g_no_wdog
      assign w_timeout = 1'b0;
    end
  endgenerate

  // Next-state selection; a watchdog abort always returns to FETCH.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_R:             w_next = S_EXEC;
          OP_ADDI, OP_SLTI: w_next = S_IMMEX;
          OP_BEQ:           w_next = S_BRANCH;
          OP_J, OP_JAL:     w_next = S_JUMP;
          OP_PERF:          w_next = S_PERF;
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_IMMEX:  w_next = S_IMMWB;
      S_IMMWB, S_BRANCH, S_JUMP, S_PERF: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
    if (w_timeout) w_next = S_FETCH;
  end

  // State register and opcode latch (captured as DECODE ends).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode;
    end
  end

  // Per-state control outputs; everything not set stays at its default.
  always_comb begin
    pc_write     = 1'b0;
    branch       = 1'b0;
    ir_write     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_dst      = REG_DST_RT;
    mem_to_reg   = M2R_ALU;
    alu_op       = ALU_FUNCT;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RT;
    pc_src       = PC_SRC_ALU;
    reg_write    = 1'b0;
    sign_or_zero = 1'b1;
    perf         = 1'b0;
    retire       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = REG_DST_RD;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_IMMEX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        alu_op       = w_imm_alu;
        sign_or_zero = w_imm_sext;
      end
      S_IMMWB: begin
        reg_write    = 1'b1;
        retire       = 1'b1;
        alu_op       = w_imm_alu;
        sign_or_zero = w_imm_sext;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
        if (r_op == OP_JAL) begin
          reg_dst    = REG_DST_RA;
          mem_to_reg = M2R_PC;
          reg_write  = 1'b1;
        end
      end
      S_PERF: begin
        perf   = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal     = (r_state == S_DECODE) && !w_known;
  assign mem_timeout = w_timeout;
  assign state       = r_state;

`ifdef PERF_COUNTERS_EN
  logic w_cnt_active;
  logic w_cnt_clear;

  assign w_cnt_active = (r_state != S_IDLE);
  assign w_cnt_clear  = (r_state == S_PERF);

  ctrl_perf_counters #(
    .W(PERF_CNT_W)
  ) u_perf_counters (
    .clk         (clk),
    .rst_n       (reset),
    .i_count     (w_cnt_active),
    .i_retire    (retire),
    .i_clear     (w_cnt_clear),
    .o_cycle_cnt (cycle_cnt),
    .o_instr_cnt (instr_cnt)
  );
`endif

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle successor to the single-cycle MIPS control decoder. A Moore FSM sequences each instruction over 3–5 cycles, and memory accesses stall on a `mem_ready` handshake. It adds:
- an optional stall watchdog,
- illegal-opcode flagging,
- optional performance counters.

It sits between the instruction register and the shared-memory datapath of the multi-cycle core.

## Interface
- `PERF_CNT_W`, 32, width of each perf counter.
- `STALL_MAX`, 0, stall-watchdog limit in cycles; 0 disables the watchdog.

Ports:
- `clk` in 1 — rising-edge clock.
- `reset` in 1 — asynchronous, active-low reset.
- `opcode` in 6 — IR[31:26]; must be stable during DECODE.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `pc_write` out 1 — unconditional PC load.
- `branch` out 1 — conditional PC load (PC loads if ALU zero).
- `ir_write` out 1 — IR load.
- `iord` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `mem_read` out 1 — memory read request.
- `mem_write` out 1 — memory write request.
- `reg_dst` out 2 — destination select: 00 rt, 01 rd, 10 $31.
- `mem_to_reg` out 2 — writeback select: 00 ALU, 01 MDR, 10 PC.
- `alu_op` out 2 — ALU mode: 00 R/funct-or-add, 01 sub, 10 slt, 11 add.
- `alu_src_a` out 1 — ALU A select: 0 = PC, 1 = rs.
- `alu_src_b` out 2 — ALU B select: 00 rt, 01 const 4, 10 imm, 11 imm<<2.
- `pc_src` out 2 — PC source: 00 ALU, 01 ALUOut, 10 jump target.
- `reg_write` out 1 — register-file write enable.
- `sign_or_zero` out 1 — 1 = sign-extend, 0 = zero-extend.
- `perf` out 1 — perf-instruction strobe.
- `retire` out 1 — one-cycle pulse in an instruction's final cycle.
- `illegal` out 1 — unrecognised opcode seen in DECODE.
- `mem_timeout` out 1 — watchdog fired.
- `state` out 4 — current state, for debug.
- `cycle_cnt` out `PERF_CNT_W` — cycle counter; present only with the perf macro.
- `instr_cnt` out `PERF_CNT_W` — retired-instruction counter; present only with the perf macro.

## Operation
- **Output decode.**
  - Outputs are a pure function of the `state` register and `op_q`, except where stated otherwise.
  - Unlisted outputs are 0, except `sign_or_zero`, which defaults to 1.
- **Opcode latch.** `op_q` latches `opcode` at the end of DECODE.
- **States, their outputs and transitions:**
  - IDLE(0): all outputs at defaults. Next state is FETCH.
  - FETCH(1): `mem_read`=1, `alu_src_b`=01, `ir_write`=`pc_write`=`mem_ready`. Moves to DECODE when `mem_ready` is high; otherwise holds.
  - DECODE(2): `alu_src_b`=11. Next state depends on `opcode`:
    - lw / sw → MEMADR.
    - R-type → EXEC.
    - addi / slti → IMMEX.
    - beq → BRANCH.
    - j / jal → JUMP.
    - 110011 → PERF.
    - any other opcode: `illegal`=1 and next state is FETCH. There is no retire and no writes.
  - MEMADR(3): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Next state is MEMRD if `op_q` is lw, else MEMWR.
  - MEMRD(4): `iord`=1, `mem_read`=1. Moves to MEMWB on `mem_ready`.
  - MEMWB(5): `mem_to_reg`=01, `reg_write`=1, `retire`=1. Next state is FETCH.
  - MEMWR(6): `iord`=1, `mem_write`=1, `retire`=`mem_ready`. Moves to FETCH on `mem_ready`.
  - EXEC(7): `alu_src_a`=1, `alu_op`=00. Next state is ALUWB.
  - ALUWB(8): `reg_dst`=01, `reg_write`=1, `retire`=1. Next state is FETCH.
  - IMMEX(9): `alu_src_a`=1, `alu_src_b`=10. `alu_op` is 11 for addi, 10 for slti. `sign_or_zero` is 0 for slti. Next state is IMMWB.
  - IMMWB(10): `reg_write`=1, `retire`=1. `alu_op` and `sign_or_zero` are held as in IMMEX. Next state is FETCH.
  - BRANCH(11): `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `branch`=1, `retire`=1. Next state is FETCH.
  - JUMP(12): `pc_src`=10, `pc_write`=1, `retire`=1. When `op_q` is jal, also `reg_dst`=10, `mem_to_reg`=10, `reg_write`=1. Next state is FETCH.
  - PERF(13): `perf`=1, `retire`=1. Next state is FETCH.
- **Stall watchdog** (`STALL_MAX`≠0):
  - A stall counter counts consecutive cycles in FETCH, MEMRD or MEMWR with `mem_ready`=0. It clears on any state change.
  - When the count reaches `STALL_MAX`, `mem_timeout` pulses for 1 cycle and the next state is FETCH, with no retire and no writes.
  - If `mem_ready` is high in that same cycle, `mem_ready` wins.
- **Illegal encodings.** Encodings 14–15 in the state register go to FETCH.

## Timing
- **Reset.** On asserting `reset`:
  - `state`, `op_q` and the stall counter go to IDLE/0 immediately.
  - All outputs go to 0, except `sign_or_zero`=1.
  - Counters go to 0.
  - Reset mid-instruction abandons the instruction with no retire.
- **First fetch.** FETCH is entered on the first rising edge after `reset` deasserts.
- **Latency with zero wait:**

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw, R-type, addi, slti | 4 |
  | beq, j, jal, perf | 3 |

  Each stall cycle adds 1.
- **`mem_ready`.** Sampled only in FETCH, MEMRD and MEMWR; ignored elsewhere.

## Configuration
- **`PERF_COUNTERS_EN` defined:**
  - `cycle_cnt` increments on every cycle not in IDLE.
  - `instr_cnt` increments on `retire`.
  - Both wrap modulo 2^`PERF_CNT_W`.
  - In PERF, both clear to 0 at the end of the cycle. Clear wins over the same-cycle increment.
- **Undefined:** the counter ports and logic are absent; the PERF state still pulses `perf` and `retire`.

## Structure
- **`ctrl_pkg` contents:**
  - state enum;
  - opcode constants (R 000000, j 000010, jal 000011, beq 000100, addi 001000, slti 001010, lw 100011, sw 101011, perf 110011);
  - `alu_op`, `reg_dst`, `mem_to_reg`, `pc_src` and `alu_src_b` encodings.
- **Sub-module `ctrl_perf_counters`:** holds both counters; instantiated only under `PERF_COUNTERS_EN`.

## Test plan
- **Reset and first fetch.** Reset low mid-MEMRD → all outputs at defaults (`sign_or_zero`=1), `state`=0 immediately; release → FETCH on the next edge.
- **lw with stall.** lw, `mem_ready` low for 2 cycles in MEMRD → 7 cycles total; `reg_write`=1 with `mem_to_reg`=01 in MEMWB; `retire` exactly once.
- **jal, slti, addi.** jal → JUMP asserts `reg_dst`=10, `mem_to_reg`=10, `pc_write`=1; slti → `sign_or_zero`=0 and `alu_op`=10 in IMMEX and IMMWB; addi → `sign_or_zero`=1 and `alu_op`=11.
- **Illegal opcode.** opcode 111111 → `illegal`=1 for one cycle in DECODE, FETCH next, no `retire`/`reg_write`.
- **Watchdog.** With `STALL_MAX`=4 and `mem_ready` held low in FETCH → `mem_timeout` pulses after the 4th stall cycle and FETCH re-enters.
- **Perf counters.** With `PERF_COUNTERS_EN`, 3 R-type instructions then perf → `instr_cnt`=3 before PERF, 0 the cycle after PERF; `cycle_cnt` also 0.
